ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction-fetch sequencer between the PC register and the decoder. Takes current pc and npc,
//  runs a req/ack transaction to a variable-latency instruction memory, holds the returned word
//  for the decoder under valid/ready, and pulses pc_en so the PC register advances only on consume.
//  Supports flush on redirect: held or in-flight instructions are discarded and pc is refetched.
// PARAMETERS
//  AW  32  address width (byte address)
//  DW  32  instruction width
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  pc           in   AW  current PC (PC register output)
//  npc          in   AW  next-PC (PC register input)
//  flush        in   1   discard held/pending instruction, refetch from pc
//  imem_req     out  1   memory request valid
//  imem_addr    out  AW  request address, stable while imem_req=1
//  imem_ack     in   1   one-cycle response strobe; imem_rdata valid this cycle
//  imem_rdata   in   DW  fetched word
//  instr_valid  out  1   instr/instr_pc valid to decoder
//  instr_ready  in   1   decoder accepts this cycle
//  instr        out  DW  held instruction
//  instr_pc     out  AW  address of held instruction
//  instr_fault  out  1   misaligned-fetch flag (IFETCH_ALIGN_CHECK_EN only)
//  pc_en        out  1   PC register load enable = instr_valid & instr_ready & !flush (combinational)
// BEHAVIOUR
//  - Reset: state IDLE; imem_req=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0, req_addr=0;
//    pc_en=0 follows from instr_valid=0. Reset mid-transaction: any later imem_ack is ignored.
//  - FSM states IDLE, REQ, HOLD, DROP (2-bit encoding).
//  - IDLE: req_addr<=pc; ->REQ. imem_req=0.
//  - REQ: imem_req=1, imem_addr=req_addr.
//     ack & !flush: instr<=imem_rdata, instr_pc<=req_addr; ->HOLD.
//     ack & flush: word discarded; ->IDLE.  !ack & flush: ->DROP.  else stay.
//  - HOLD: instr_valid=1; instr/instr_pc stable until consumed or flushed.
//     flush (priority over ready): ->IDLE, pc_en=0.
//     ready & !flush: pc_en=1; req_addr<=npc; ->REQ (PC register and req_addr update same edge).
//  - DROP: imem_req=0; waiting for stale ack. ack: discarded, ->IDLE. flush in DROP: no effect.
//  - imem_ack outside REQ/DROP is ignored.
//  - Latency: pc to instr_valid = 2 cycles + memory wait; zero-wait memory gives one instruction
//    per 2 cycles sustained. No outstanding-request overlap (max 1 in flight).
//  - AW/DW arithmetic: none beyond the register copies; no wrap logic (npc supplied externally).
// CONFIGURATION
//  IFETCH_ALIGN_CHECK_EN defined: in IDLE and on HOLD->REQ, if next req_addr[1:0]!=0, no memory
//   request is issued; go directly to HOLD with instr=0 (nop), instr_fault=1, instr_pc=address.
//   instr_fault clears when that entry is consumed or flushed.
//  Not defined: no check; imem_addr passes bits [1:0] unchanged; instr_fault tied 0.
// STRUCTURE
//  Package ifetch_pkg: state typedef/localparams (IDLE=0,REQ=1,HOLD=2,DROP=3), NOP word 32'h0.
//  Single module; no sub-module. FSM next-state in one combinational block, registers in one
//  sequential block.
// TESTING
//  1 rst high 2 cycles, pc=0x3000, ack 2 cycles after req with 0x20080005 -> imem_addr=0x3000,
//    instr_valid=1, instr=0x20080005, instr_pc=0x3000; imem_req/instr_valid=0 during reset.
//  2 HOLD, instr_ready=0 for 3 cycles then 1, npc=0x3004 -> instr stable, pc_en single pulse,
//    next imem_addr=0x3004.
//  3 REQ at 0x3004, flush at cycle 1, ack at cycle 3 with 0xDEADBEEF -> DROP, word never valid;
//    new request at current pc (e.g. 0x3040) after ack.
//  4 flush and ack same cycle -> no instr_valid; IDLE then REQ at pc.
//  5 HOLD with flush and instr_ready both 1 -> pc_en=0, instr_valid 0 next cycle.
//  6 IFETCH_ALIGN_CHECK_EN, pc=0x3002 -> no imem_req, instr_valid=1, instr=0, instr_fault=1;
//    without macro imem_addr=0x3002, instr_fault=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The IFETCH_ALIGN_CHECK_EN build option is consumed in ifetch_unit.sv.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Fetch sequencer: one req/ack memory transaction at a time, holds the word for the decoder.
// Build option IFETCH_ALIGN_CHECK_EN turns misaligned fetch addresses into faulting nops.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] npc,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_fault,
  output logic          pc_en
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] req_addr_r;
  logic [AW-1:0] req_addr_nxt_s;
  logic [DW-1:0] instr_nxt_s;
  logic [AW-1:0] instr_pc_nxt_s;
  logic          fault_nxt_s;

  assign imem_addr = req_addr_r;
  // The PC register advances only when the held word is really consumed.
  assign pc_en     = instr_valid & instr_ready & ~flush;

  // Next-state and next-register values for the fetch FSM.
  always_comb begin
    state_nxt_s    = state_r;
    req_addr_nxt_s = req_addr_r;
    instr_nxt_s    = instr;
    instr_pc_nxt_s = instr_pc;
    fault_nxt_s    = instr_fault;
    case (state_r)
      IDLE: begin
        req_addr_nxt_s = pc;
`ifdef IFETCH_ALIGN_CHECK_EN
        if (misaligned(pc[1:0])) begin
          state_nxt_s    = HOLD;
          instr_nxt_s    = DW'(NOP_WORD);
          instr_pc_nxt_s = pc;
          fault_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = REQ;
        end
`else
        state_nxt_s = REQ;
`endif
      end
      REQ: begin
        if (imem_ack && !flush) begin
          state_nxt_s    = HOLD;
          instr_nxt_s    = imem_rdata;
          instr_pc_nxt_s = req_addr_r;
        end else if (imem_ack) begin
          state_nxt_s = IDLE;
        end else if (flush) begin
          // Response still owed by memory; swallow it before refetching.
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt_s = IDLE;
          fault_nxt_s = 1'b0;
        end else if (instr_ready) begin
          state_nxt_s    = REQ;
          req_addr_nxt_s = npc;
          fault_nxt_s    = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misaligned(npc[1:0])) begin
            state_nxt_s    = HOLD;
            instr_nxt_s    = DW'(NOP_WORD);
            instr_pc_nxt_s = npc;
            fault_nxt_s    = 1'b1;
          end else begin
            state_nxt_s = REQ;
          end
`endif
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, address and held-instruction registers; handshake outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      req_addr_r  <= {AW{1'b0}};
      instr       <= {DW{1'b0}};
      instr_pc    <= {AW{1'b0}};
      instr_fault <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_addr_r  <= req_addr_nxt_s;
      instr       <= instr_nxt_s;
      instr_pc    <= instr_pc_nxt_s;
      instr_fault <= fault_nxt_s;
      imem_req    <= (state_nxt_s == REQ);
      instr_valid <= (state_nxt_s == HOLD);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed corner sequences plus a table-driven fetch stream.
// Honours IFETCH_ALIGN_CHECK_EN to pick the expected misaligned-fetch behaviour.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        pc_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] addr;
    int          wait_cyc;
    logic [31:0] data;
    int          rdy_dly;
  } vec_t;
  vec_t vt[6];

  ifetch_unit #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .npc        (npc),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_fault(instr_fault),
    .pc_en      (pc_en)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 50) begin
      step();
      n++;
    end
    check1({name, "_req_timeout"}, imem_req, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    check1({name, "_valid_timeout"}, instr_valid, 1'b1);
  endtask

  task automatic consume_check(input string name);
    exp_t e;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got consume with empty scoreboard, expected a pending word", name);
    end else begin
      e = sbq.pop_front();
      check32({name, "_instr"}, instr, e.d);
      check32({name, "_instr_pc"}, instr_pc, e.a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = 32'h0000_3000; npc = 32'h0000_3004; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

    // 1: reset values, then first fetch with two wait cycles
    step(); samp();
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_instr_pc", instr_pc, 32'h0);
    check1("rst_fault", instr_fault, 1'b0);
    check1("rst_pc_en", pc_en, 1'b0);
    step(); samp();
    check1("rst2_req", imem_req, 1'b0);
    check1("rst2_valid", instr_valid, 1'b0);
    step(); rst = 1'b0;
    step(); samp();
    check1("t1_req", imem_req, 1'b1);
    check32("t1_addr", imem_addr, 32'h0000_3000);
    step(); samp();
    check1("t1_req_held", imem_req, 1'b1);
    step(); imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    sbq.push_back('{a: 32'h0000_3000, d: 32'h2008_0005});
    samp();
    check1("t1_valid_early", instr_valid, 1'b0);
    step(); imem_ack = 1'b0; samp();
    check1("t1_valid", instr_valid, 1'b1);
    check32("t1_instr", instr, 32'h2008_0005);
    check32("t1_instr_pc", instr_pc, 32'h0000_3000);
    check1("t1_req_off", imem_req, 1'b0);

    // 2: stall three cycles (stray ack in HOLD ignored), then a single consume pulse
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ack = (i == 0); imem_rdata = 32'hBAD0_BAD0;
      samp();
      check1("t2_stall_valid", instr_valid, 1'b1);
      check32("t2_stall_instr", instr, 32'h2008_0005);
      check1("t2_stall_pc_en", pc_en, 1'b0);
    end
    step(); imem_ack = 1'b0; npc = 32'h0000_3004; instr_ready = 1'b1; samp();
    check1("t2_pc_en", pc_en, 1'b1);
    consume_check("t2");
    step(); instr_ready = 1'b0; pc = 32'h0000_3004; npc = 32'h0000_3008; samp();
    check1("t2_pc_en_off", pc_en, 1'b0);
    check1("t2_valid_off", instr_valid, 1'b0);
    check1("t2_req", imem_req, 1'b1);
    check32("t2_addr", imem_addr, 32'h0000_3004);

    // 3: flush while request pending, stale ack two cycles later is dropped
    step(); flush = 1'b1; pc = 32'h0000_3040; samp();
    check1("t3_valid_c1", instr_valid, 1'b0);
    step(); flush = 1'b0; samp();
    check1("t3_drop_req", imem_req, 1'b0);
    step(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; samp();
    check1("t3_ack_valid", instr_valid, 1'b0);
    step(); imem_ack = 1'b0; samp();
    check1("t3_idle_valid", instr_valid, 1'b0);
    check1("t3_idle_req", imem_req, 1'b0);
    step(); samp();
    check1("t3_req", imem_req, 1'b1);
    check32("t3_addr", imem_addr, 32'h0000_3040);
    check1("t3_valid_never", instr_valid, 1'b0);

    // 4: flush and ack in the same cycle
    step(); imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'h1111_1111; pc = 32'h0000_3080; samp();
    check1("t4_pc_en", pc_en, 1'b0);
    step(); imem_ack = 1'b0; flush = 1'b0; samp();
    check1("t4_idle_valid", instr_valid, 1'b0);
    check1("t4_idle_req", imem_req, 1'b0);
    step(); samp();
    check1("t4_req", imem_req, 1'b1);
    check32("t4_addr", imem_addr, 32'h0000_3080);
    check1("t4_valid", instr_valid, 1'b0);

    // 5: flush wins over ready in HOLD
    step(); imem_ack = 1'b1; imem_rdata = 32'h2222_2222; samp();
    step(); imem_ack = 1'b0; samp();
    check1("t5_valid", instr_valid, 1'b1);
    check32("t5_instr", instr, 32'h2222_2222);
    step(); flush = 1'b1; instr_ready = 1'b1; samp();
    check1("t5_pc_en", pc_en, 1'b0);
    step(); flush = 1'b0; instr_ready = 1'b0; samp();
    check1("t5_valid_off", instr_valid, 1'b0);
    step(); samp();
    check32("t5_refetch_addr", imem_addr, 32'h0000_3080);
    check1("t5_refetch_req", imem_req, 1'b1);

    // 6: misaligned fetch address
    step(); rst = 1'b1; pc = 32'h0000_3002;
    step(); rst = 1'b0;
    step(); samp();
`ifdef IFETCH_ALIGN_CHECK_EN
    check1("t6_req", imem_req, 1'b0);
    check1("t6_valid", instr_valid, 1'b1);
    check32("t6_instr", instr, 32'h0);
    check32("t6_instr_pc", instr_pc, 32'h0000_3002);
    check1("t6_fault", instr_fault, 1'b1);
    step(); npc = 32'h0000_3008; instr_ready = 1'b1; samp();
    check1("t6_pc_en", pc_en, 1'b1);
    step(); instr_ready = 1'b0; pc = 32'h0000_3008; samp();
    check1("t6_fault_clr", instr_fault, 1'b0);
    check1("t6_next_req", imem_req, 1'b1);
    check32("t6_next_addr", imem_addr, 32'h0000_3008);
`else
    check1("t6_req", imem_req, 1'b1);
    check32("t6_addr", imem_addr, 32'h0000_3002);
    check1("t6_fault", instr_fault, 1'b0);
    check1("t6_valid", instr_valid, 1'b0);
`endif

    // table-driven fetch stream with varied memory waits and decoder stalls
    vt[0] = '{addr: 32'h0000_4000, wait_cyc: 0, data: 32'h0000_0013, rdy_dly: 0};
    vt[1] = '{addr: 32'h0000_4004, wait_cyc: 1, data: 32'h0010_0093, rdy_dly: 2};
    vt[2] = '{addr: 32'h0000_4008, wait_cyc: 3, data: 32'hFFF0_0113, rdy_dly: 0};
    vt[3] = '{addr: 32'h0000_5000, wait_cyc: 0, data: 32'h0000_006F, rdy_dly: 1};
    vt[4] = '{addr: 32'h0000_5004, wait_cyc: 2, data: 32'hA5A5_A5A5, rdy_dly: 0};
    vt[5] = '{addr: 32'h0000_5008, wait_cyc: 0, data: 32'h1234_5678, rdy_dly: 3};

    step(); rst = 1'b1; pc = vt[0].addr;
    step();
    step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_req("s");
      check32("s_addr", imem_addr, vt[i].addr);
      for (int w = 0; w < vt[i].wait_cyc; w++) begin
        samp();
        check32("s_addr_stable", imem_addr, vt[i].addr);
        step();
      end
      imem_ack = 1'b1; imem_rdata = vt[i].data;
      sbq.push_back('{a: vt[i].addr, d: vt[i].data});
      samp();
      step(); imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
      wait_valid("s");
      for (int r = 0; r < vt[i].rdy_dly; r++) begin
        samp();
        check1("s_stall_pc_en", pc_en, 1'b0);
        step();
      end
      npc = (i < 5) ? vt[i + 1].addr : vt[i].addr + 32'd4;
      instr_ready = 1'b1;
      samp();
      check1("s_pc_en", pc_en, 1'b1);
      consume_check("s");
      step(); instr_ready = 1'b0; pc = npc;
    end
    check32("s_scoreboard_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
